// File: rtl/trigger_time_recorder_if.sv
// Write port into the trigger-timing memory: one word per wr_en cycle.
interface trigger_time_recorder_if;
  logic        wr_en;
  logic [13:0] wr_addr;
  logic [29:0] wr_data;

  modport master (output wr_en, wr_addr, wr_data);
  modport slave  (input  wr_en, wr_addr, wr_data);
endinterface

// File: rtl/trigger_time_recorder.sv
// Records trigger rising-edge times after an arm pulse into the replay table (addr 0 = count).
// Optional TRIG_REC_GLITCH_FILTER_EN: edges must be high for two samples; timestamp = first high sample.
//
// state  | meaning
// IDLE   | waiting for arm; outputs of the last run held
// ARMED  | timer running, edges recorded
// FLUSH  | run terminated; last entry write (if any) on the bus
// HEADER | header word on the bus, done pulsing
module trigger_time_recorder (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           arm,
  input  logic                           stop,
  input  logic                           trig_in,
  input  logic [13:0]                    max_triggers,
  trigger_time_recorder_if.master        wr_bus,
  output logic                           busy,
  output logic                           done,
  output logic [13:0]                    trig_count,
  output logic                           overflow
);
  typedef enum logic [1:0] {IDLE, ARMED, FLUSH, HEADER} state_t;

  localparam logic [29:0] TIMER_MAX = '1;

  state_t      state;
  logic [29:0] timer;
  logic [13:0] limit;
  logic        trig_d;
  logic        wr_en_q;
  logic [13:0] wr_addr_q;
  logic [29:0] wr_data_q;

  logic        edge_det;
  logic        flush_edge;
  logic [29:0] edge_time;
  logic [13:0] count_inc;
  logic        limit_hit;
  logic        timer_sat;

`ifdef TRIG_REC_GLITCH_FILTER_EN
  logic        cand_valid;
  logic [29:0] cand_time;

  // A candidate seen in the terminating cycle may still qualify while in FLUSH.
  assign edge_det   = cand_valid & trig_in;
  assign edge_time  = cand_time;
  assign flush_edge = edge_det;
`else
  assign edge_det   = trig_in & ~trig_d;
  assign edge_time  = timer;
  assign flush_edge = 1'b0;
`endif

  assign count_inc = trig_count + 14'd1;
  assign limit_hit = edge_det && (count_inc >= limit);
  assign timer_sat = (timer == TIMER_MAX);

  assign wr_bus.wr_en   = wr_en_q;
  assign wr_bus.wr_addr = wr_addr_q;
  assign wr_bus.wr_data = wr_data_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      timer      <= '0;
      limit      <= '0;
      trig_d     <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      trig_count <= '0;
      overflow   <= 1'b0;
`ifdef TRIG_REC_GLITCH_FILTER_EN
      cand_valid <= 1'b0;
      cand_time  <= '0;
`endif
    end else begin
      trig_d  <= trig_in;
      wr_en_q <= 1'b0;
      done    <= 1'b0;
`ifdef TRIG_REC_GLITCH_FILTER_EN
      cand_valid <= (state == ARMED) && trig_in && !trig_d;
      cand_time  <= timer;
`endif
      unique case (state)
        IDLE: begin
          if (arm) begin
            state      <= ARMED;
            busy       <= 1'b1;
            // Cycle A+n must see n, so the register is loaded with 1 at the arm edge.
            timer      <= 30'd1;
            trig_count <= '0;
            overflow   <= 1'b0;
            limit      <= (max_triggers == 14'd0) ? 14'h3FFF : max_triggers;
          end
        end
        ARMED: begin
          if (edge_det) begin
            wr_en_q    <= 1'b1;
            wr_addr_q  <= count_inc;
            wr_data_q  <= edge_time;
            trig_count <= count_inc;
          end
          if (stop || limit_hit || timer_sat) begin
            state    <= FLUSH;
            overflow <= overflow | timer_sat;
          end else begin
            timer <= timer + 30'd1;
          end
        end
        FLUSH: begin
          if (flush_edge) begin
            wr_en_q    <= 1'b1;
            wr_addr_q  <= count_inc;
            wr_data_q  <= edge_time;
            trig_count <= count_inc;
          end else begin
            wr_en_q   <= 1'b1;
            wr_addr_q <= '0;
            wr_data_q <= {16'b0, trig_count};
            done      <= 1'b1;
            state     <= HEADER;
          end
        end
        HEADER: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_trigger_time_recorder.sv
// Bench for trigger_time_recorder: directed table, hand sequences and random runs vs a timeline model.
module tb_trigger_time_recorder;
  logic        clk = 1'b0;
  logic        reset, arm, stop, trig_in;
  logic [13:0] max_triggers;
  logic        busy, done, overflow;
  logic [13:0] trig_count;

  trigger_time_recorder_if mem_if ();

  trigger_time_recorder dut (
    .clk          (clk),
    .reset        (reset),
    .arm          (arm),
    .stop         (stop),
    .trig_in      (trig_in),
    .max_triggers (max_triggers),
    .wr_bus       (mem_if),
    .busy         (busy),
    .done         (done),
    .trig_count   (trig_count),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [13:0]  max;
    logic         pre;
    logic [127:0] pat;      // bit i = trig_in level at A+i
    int           stop_at;  // -1: none
    int           rearm_at;
    int           reset_at;
    int           win;
    int           exp_hdr;  // header cycle rel A; -1 none; -2 unchecked
    int           exp_count;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_bad = 0;

  logic exp_busy [0:127];
  logic exp_done [0:127];
  logic exp_we   [0:127];
  int   exp_addr [0:127];
  int   exp_data [0:127];
  int   exp_cnt  [0:127];

  function automatic logic [127:0] mk_pat(int s0, int l0, int s1, int l1, int s2, int l2);
    logic [127:0] p;
    p = '0;
    for (int i = 0; i < l0; i++) p[s0+i] = 1'b1;
    for (int i = 0; i < l1; i++) p[s1+i] = 1'b1;
    for (int i = 0; i < l2; i++) p[s2+i] = 1'b1;
    return p;
  endfunction

  task automatic add_vec(input logic [13:0] max, input logic pre, input logic [127:0] pat,
                         input int stop_at, input int rearm_at, input int reset_at,
                         input int win, input int exp_hdr, input int exp_count);
    vec_t v;
    v.max = max; v.pre = pre; v.pat = pat; v.stop_at = stop_at; v.rearm_at = rearm_at;
    v.reset_at = reset_at; v.win = win; v.exp_hdr = exp_hdr; v.exp_count = exp_count;
    vecs.push_back(v);
  endtask

  // Timeline model: list the honoured edges, find the terminating cycle, then place each write.
  task automatic build_model(input vec_t v);
    int edges[$];
    int lim, t;
    lim = (v.max == 14'd0) ? 16383 : int'(v.max);
    t = -1;
    for (int n = 1; n <= v.win; n++) begin
      if (t < 0) begin
        if (v.pat[n] && !v.pat[n-1]) edges.push_back(n);
        if (n == v.stop_at || (v.pat[n] && !v.pat[n-1] && edges.size() == lim)) t = n;
      end
    end
    for (int i = 0; i <= v.win; i++) begin
      exp_busy[i] = (i >= 1) && (t < 0 || i <= t + 2);
      exp_done[i] = (t >= 0) && (i == t + 2);
      exp_we[i]   = 1'b0;
      exp_addr[i] = 0;
      exp_data[i] = 0;
      exp_cnt[i]  = 0;
      foreach (edges[k]) if (edges[k] < i) exp_cnt[i]++;
    end
    foreach (edges[k]) begin
      if (edges[k] + 1 <= v.win) begin
        exp_we[edges[k]+1]   = 1'b1;
        exp_addr[edges[k]+1] = k + 1;
        exp_data[edges[k]+1] = edges[k];
      end
    end
    if (t >= 0 && t + 2 <= v.win) begin
      exp_we[t+2]   = 1'b1;
      exp_addr[t+2] = 0;
      exp_data[t+2] = edges.size();
    end
    if (v.reset_at >= 0) begin
      for (int i = v.reset_at + 1; i <= v.win; i++) begin
        exp_busy[i] = 1'b0; exp_done[i] = 1'b0; exp_we[i] = 1'b0;
        exp_addr[i] = 0; exp_data[i] = 0; exp_cnt[i] = 0;
      end
    end
  endtask

  task automatic check_cycle(input int idx, input int i);
    logic [61:0] got, want;
    got  = {busy, done, mem_if.wr_en,
            exp_we[i] ? mem_if.wr_addr : 14'd0,
            exp_we[i] ? mem_if.wr_data : 30'd0,
            trig_count, overflow};
    want = {exp_busy[i], exp_done[i], exp_we[i], 14'(exp_addr[i]), 30'(exp_data[i]),
            14'(exp_cnt[i]), 1'b0};
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL cycle vec%0d A+%0d: got {busy,done,we,addr,data,cnt,ovf}=%h required %h",
               idx, i, got, want);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int hdr_cyc, hdr_cnt;
    build_model(v);
    hdr_cyc = -1;
    hdr_cnt = -1;
    reset = 1'b1; arm = 1'b0; stop = 1'b0; trig_in = v.pre; max_triggers = v.max;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    arm = 1'b1; trig_in = v.pat[0]; stop = (v.stop_at == 0);
    for (int i = 1; i <= v.win; i++) begin
      @(negedge clk);
      check_cycle(idx, i);
      if (mem_if.wr_en && mem_if.wr_addr == 14'd0 && hdr_cyc < 0) begin
        hdr_cyc = i;
        hdr_cnt = int'(mem_if.wr_data);
      end
      arm = (i == v.rearm_at); trig_in = v.pat[i]; stop = (i == v.stop_at); reset = (i == v.reset_at);
    end
    arm = 1'b0; stop = 1'b0; reset = 1'b0; trig_in = 1'b0;
    if (v.exp_hdr != -2) begin
      n_vec++;
      if (hdr_cyc != v.exp_hdr || (v.exp_hdr >= 0 && hdr_cnt != v.exp_count)) begin
        n_bad++;
        $display("FAIL header vec%0d: got cycle %0d count %0d, required cycle %0d count %0d",
                 idx, hdr_cyc, hdr_cnt, v.exp_hdr, v.exp_count);
      end
    end
  endtask

  initial begin
    vec_t rv;
    reset = 1'b1; arm = 1'b0; stop = 1'b0; trig_in = 1'b0; max_triggers = '0;

    //        max pre pattern                        stop rearm rst win hdr cnt
    add_vec(14'd3, 0, mk_pat(5, 2, 30, 1, 40, 2),   -1,  -1,  -1, 50, 42, 3);
    add_vec(14'd0, 0, mk_pat(7, 1, 9, 1, 0, 0),     20,  -1,  -1, 30, 22, 2);
    add_vec(14'd0, 0, mk_pat(4, 2, 12, 3, 0, 0),    12,  -1,  -1, 24, 14, 2);
    add_vec(14'd0, 1, mk_pat(0, 3, 5, 3, 0, 0),     15,   8,  -1, 24, 17, 1);
    add_vec(14'd0, 0, mk_pat(2, 2, 9, 2, 0, 0),     -1,  -1,   6, 16, -1, 0);
    add_vec(14'd1, 0, mk_pat(1, 1, 4, 2, 0, 0),     -1,  -1,  -1, 10,  3, 1);
    add_vec(14'd0, 0, mk_pat(0, 0, 0, 0, 0, 0),      1,  -1,  -1, 10,  3, 0);
    add_vec(14'd1, 0, mk_pat(0, 1, 2, 1, 0, 0),     -1,  -1,  -1, 10,  4, 1);
    add_vec(14'd2, 0, mk_pat(3, 1, 5, 1, 7, 1),     -1,  -1,  -1, 14,  7, 2);

    @(negedge clk);
    @(negedge clk);
    n_vec++;
    if ({busy, done, mem_if.wr_en, mem_if.wr_addr, mem_if.wr_data, trig_count, overflow} !== 62'd0) begin
      n_bad++;
      $display("FAIL reset_state: got busy=%0b done=%0b we=%0b addr=%0d data=%0d cnt=%0d ovf=%0b, required all 0",
               busy, done, mem_if.wr_en, mem_if.wr_addr, mem_if.wr_data, trig_count, overflow);
    end

    for (int k = 0; k < vecs.size(); k++) run_vec(vecs[k], k);

    // Count holds after done, then clears on the next arm.
    run_vec(vecs[0], 100);
    repeat (3) @(negedge clk);
    n_vec++;
    if (trig_count !== 14'd3 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL hold_after_done: got cnt=%0d busy=%0b, required cnt=3 busy=0", trig_count, busy);
    end
    arm = 1'b1;
    @(negedge clk);
    arm = 1'b0;
    n_vec++;
    if (trig_count !== 14'd0 || busy !== 1'b1 || done !== 1'b0) begin
      n_bad++;
      $display("FAIL rearm_clear: got cnt=%0d busy=%0b done=%0b, required cnt=0 busy=1 done=0",
               trig_count, busy, done);
    end

    for (int k = 0; k < 20; k++) begin
      rv.max      = 14'($urandom_range(0, 8));
      rv.pre      = 1'($urandom_range(0, 1));
      rv.pat      = '0;
      for (int i = 0; i <= 70; i++) rv.pat[i] = ($urandom_range(0, 2) == 0);
      rv.stop_at  = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(5, 65));
      rv.rearm_at = ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(1, 3));
      rv.reset_at = -1;
      rv.win      = 70;
      rv.exp_hdr  = -2;
      rv.exp_count = 0;
      run_vec(rv, 200 + k);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
